voice_scheduler: RTL and testbench

- Polyphony controller between the keypad inputs and the oscillator / wave shaper / signal mixer datapath.
- Once per sample tick it scans the 12 note keys and allocates up to NUM_VOICES voices, stealing the oldest voice when all are busy.
- Drives the mixer's 12-bit sample_enable, per-voice note indices, the wave-shape mode selected by modekey, and a gain shift that keeps the 8-bit mixer sum from wrapping.

---
 rtl/voice_scheduler_if.sv | 29 ++
 rtl/voice_scheduler.sv | 234 +++++++++++++++++++++++
 tb/tb_voice_scheduler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_scheduler_if.sv
// rtl/voice_scheduler_if.sv - keypad-side inputs and mixer-side outputs of the voice scheduler
interface voice_scheduler_if #(
    parameter int NUM_KEYS   = 12,
    parameter int NUM_VOICES = 4
) ();
    logic [NUM_KEYS-1:0]     keys;
    logic                    modekey;
    logic                    sample_now;
    logic [NUM_KEYS-1:0]     sample_enable;
    logic [NUM_VOICES-1:0]   voice_active;
    logic [4*NUM_VOICES-1:0] voice_notes;
    logic [1:0]              mode;
    logic [1:0]              gain_shift;
    logic                    update;
    logic                    busy;
    logic                    overrun;

    modport master (
        output keys, modekey, sample_now,
        input  sample_enable, voice_active, voice_notes, mode, gain_shift,
        input  update, busy, overrun
    );

    modport slave (
        input  keys, modekey, sample_now,
        output sample_enable, voice_active, voice_notes, mode, gain_shift,
        output update, busy, overrun
    );
endinterface

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - per-tick key scan with oldest-voice stealing, commits enables to the mixer
module voice_scheduler #(
    parameter int NUM_KEYS   = 12,
    parameter int NUM_VOICES = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    voice_scheduler_if.slave   bus
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int IW = $clog2(NUM_KEYS);
    localparam int CW = $clog2(NUM_VOICES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [VW-1:0] RANK_MAX = VW'(NUM_VOICES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_KEYS - 1);

    logic [NUM_KEYS-1:0]             keys_meta_q, keys_sync_q;
    logic [1:0]                      state_q, state_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic [NUM_VOICES-1:0]           act_q, act_d;
    logic [NUM_VOICES-1:0][3:0]      note_q, note_d;
    logic [NUM_VOICES-1:0][VW-1:0]   rank_q, rank_d;
    logic [NUM_KEYS-1:0]             stolen_q, stolen_d;

    logic [NUM_KEYS-1:0]             sample_enable_q;
    logic [NUM_VOICES-1:0]           voice_active_q;
    logic [4*NUM_VOICES-1:0]         voice_notes_q;
    logic [1:0]                      mode_q;
    logic [1:0]                      gain_shift_q;
    logic                            update_q;
    logic                            overrun_q;

    logic [3:0]                      cur_note;
    logic                            pressed;
    logic                            hit;
    logic [VW-1:0]                   hit_v;
    logic                            free_found;
    logic [VW-1:0]                   free_v;
    logic [VW-1:0]                   steal_v;
    logic [VW-1:0]                   steal_rank;
    logic [VW-1:0]                   alloc_v;
    logic [NUM_KEYS-1:0]             enable_next;
    logic [CW-1:0]                   active_cnt;
    logic [1:0]                      gain_next;

    assign cur_note = 4'(idx_q);
    assign pressed  = keys_sync_q[idx_q];

    // Two-flop synchronizer for the raw key levels
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            keys_meta_q <= '0;
            keys_sync_q <= '0;
        end else begin
            keys_meta_q <= bus.keys;
            keys_sync_q <= keys_meta_q;
        end
    end

    // Voice lookup for the key under scan: holder, lowest free voice, oldest voice
    always_comb begin
        hit        = 1'b0;
        hit_v      = '0;
        free_found = 1'b0;
        free_v     = '0;
        steal_v    = '0;
        steal_rank = rank_q[0];
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (act_q[v] && (note_q[v] == cur_note) && !hit) begin
                hit   = 1'b1;
                hit_v = VW'(v);
            end
        end
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!act_q[v]) begin
                free_found = 1'b1;
                free_v     = VW'(v);
            end
        end
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (rank_q[v] > steal_rank) begin
                steal_rank = rank_q[v];
                steal_v    = VW'(v);
            end
        end
        alloc_v = free_found ? free_v : steal_v;
    end

    // Scan sequencing and the one shadow update allowed per scanned key
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        act_d    = act_q;
        note_d   = note_q;
        rank_d   = rank_q;
        stolen_d = stolen_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.sample_now) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                if (pressed) begin
                    if (!hit && !stolen_q[idx_q]) begin
                        if (!free_found) begin
                            stolen_d[note_q[steal_v]] = 1'b1;
                        end
                        act_d[alloc_v]  = 1'b1;
                        note_d[alloc_v] = cur_note;
                        rank_d[alloc_v] = '0;
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if ((VW'(v) != alloc_v) && act_q[v] && (rank_q[v] != RANK_MAX)) begin
                                rank_d[v] = rank_q[v] + 1'b1;
                            end
                        end
                    end
                end else begin
                    stolen_d[idx_q] = 1'b0;
                    if (hit) begin
                        act_d[hit_v]  = 1'b0;
                        rank_d[hit_v] = '0;
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (act_q[v] && (rank_q[v] > rank_q[hit_v])) begin
                                rank_d[v] = rank_q[v] - 1'b1;
                            end
                        end
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and shadow voice state
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            act_q    <= '0;
            note_q   <= '0;
            rank_q   <= '0;
            stolen_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            act_q    <= act_d;
            note_q   <= note_d;
            rank_q   <= rank_d;
            stolen_q <= stolen_d;
        end
    end

    // Mixer enables and gain derived from the shadow voices
    always_comb begin
        enable_next = '0;
        active_cnt  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (act_q[v]) begin
                enable_next[note_q[v]] = 1'b1;
                active_cnt = active_cnt + 1'b1;
            end
        end
        if (active_cnt >= CW'(3)) begin
            gain_next = 2'd2;
        end else if (active_cnt == CW'(2)) begin
            gain_next = 2'd1;
        end else begin
            gain_next = 2'd0;
        end
    end

    // Commit shadow to outputs and flag a change of the enable set
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            sample_enable_q <= '0;
            voice_active_q  <= '0;
            voice_notes_q   <= '0;
            gain_shift_q    <= '0;
            update_q        <= 1'b0;
        end else begin
            update_q <= 1'b0;
            if (state_q == ST_COMMIT) begin
                sample_enable_q <= enable_next;
                voice_active_q  <= act_q;
                voice_notes_q   <= note_q;
                gain_shift_q    <= gain_next;
                update_q        <= (enable_next != sample_enable_q);
            end
        end
    end

    // Wave-shape mode stepping, independent of the scan
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            mode_q <= 2'd0;
        end else if (bus.modekey) begin
            mode_q <= mode_q + 2'd1;
        end
    end

    // Sticky record of ticks dropped while a scan was in progress
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            overrun_q <= 1'b0;
        end else if (bus.sample_now && (state_q != ST_IDLE)) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.sample_enable = sample_enable_q;
    assign bus.voice_active  = voice_active_q;
    assign bus.voice_notes   = voice_notes_q;
    assign bus.mode          = mode_q;
    assign bus.gain_shift    = gain_shift_q;
    assign bus.update        = update_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - randomized scoreboard bench for voice_scheduler against an age-list model
module tb_voice_scheduler;
    logic clk;
    logic n_rst;

    voice_scheduler_if #(.NUM_KEYS(12), .NUM_VOICES(4)) bus ();

    voice_scheduler #(.NUM_KEYS(12), .NUM_VOICES(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] se;
        logic [3:0]  va;
        logic [15:0] vn;
        logic [1:0]  gs;
        logic        upd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_mode = 0;

    bit          m_act[4];
    int          m_note[4];
    int          m_age[$];
    bit          m_stolen[12];
    logic [11:0] m_prev_se;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mask_notes(input logic [15:0] n, input logic [3:0] a);
        logic [15:0] r;
        r = '0;
        for (int v = 0; v < 4; v++) if (a[v]) r[4*v +: 4] = n[4*v +: 4];
        return r;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 4; v++) begin
            m_act[v]  = 1'b0;
            m_note[v] = 0;
        end
        for (int k = 0; k < 12; k++) m_stolen[k] = 1'b0;
        m_age.delete();
        m_prev_se = '0;
    endtask

    // m_age lists voice numbers newest first, so the oldest voice is the last entry
    task automatic model_tick(input logic [11:0] k, output exp_t e);
        int cnt;
        for (int key = 0; key < 12; key++) begin
            int hv = -1;
            for (int v = 0; v < 4; v++) if (m_act[v] && m_note[v] == key) hv = v;
            if (k[key]) begin
                if (hv < 0 && !m_stolen[key]) begin
                    int fv = -1;
                    for (int v = 3; v >= 0; v--) if (!m_act[v]) fv = v;
                    if (fv < 0) begin
                        fv = m_age[$];
                        m_age.pop_back();
                        m_stolen[m_note[fv]] = 1'b1;
                    end
                    m_act[fv]  = 1'b1;
                    m_note[fv] = key;
                    m_age.push_front(fv);
                end
            end else begin
                m_stolen[key] = 1'b0;
                if (hv >= 0) begin
                    int pos = -1;
                    m_act[hv] = 1'b0;
                    for (int i = 0; i < m_age.size(); i++) if (m_age[i] == hv) pos = i;
                    if (pos >= 0) m_age.delete(pos);
                end
            end
        end
        e.se = '0; e.va = '0; e.vn = '0; cnt = 0;
        for (int v = 0; v < 4; v++) begin
            if (m_act[v]) begin
                e.se[m_note[v]] = 1'b1;
                e.va[v] = 1'b1;
                e.vn[4*v +: 4] = 4'(m_note[v]);
                cnt++;
            end
        end
        e.gs  = (cnt >= 3) ? 2'd2 : (cnt == 2) ? 2'd1 : 2'd0;
        e.upd = (e.se != m_prev_se);
        m_prev_se = e.se;
    endtask

    // Monitor: a busy-to-idle transition outside reset is a commit
    initial begin
        bit prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !bus.busy) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_commit", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("commit_sample_enable", 32'(bus.sample_enable), 32'(e.se));
                        check("commit_voice_active", 32'(bus.voice_active), 32'(e.va));
                        check("commit_voice_notes", 32'(mask_notes(bus.voice_notes, bus.voice_active)), 32'(e.vn));
                        check("commit_gain_shift", 32'(bus.gain_shift), 32'(e.gs));
                        check("commit_update", 32'(bus.update), 32'(e.upd));
                    end
                end
                prev_busy = bus.busy;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_drop_within_budget", 32'(bus.busy), 32'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_tick(input logic mk);
        @(posedge clk);
        #1;
        bus.sample_now = 1'b1;
        bus.modekey    = mk;
        @(posedge clk);
        #1;
        bus.sample_now = 1'b0;
        bus.modekey    = 1'b0;
        if (mk) exp_mode = (exp_mode + 1) % 4;
    endtask

    task automatic do_tick(input logic [11:0] k, input logic mk);
        exp_t e;
        bus.keys = k;
        repeat (3) @(posedge clk);
        model_tick(k, e);
        sb_q.push_back(e);
        pulse_tick(mk);
        check("mode_after_tick", 32'(bus.mode), 32'(exp_mode));
        wait_idle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b0;
        model_reset();
        exp_mode = 0;
        sb_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst          = 1'b1;
        bus.keys       = '0;
        bus.modekey    = 1'b0;
        bus.sample_now = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample_enable", 32'(bus.sample_enable), 32'd0);
        check("rst_voice_active", 32'(bus.voice_active), 32'd0);
        check("rst_voice_notes", 32'(bus.voice_notes), 32'd0);
        check("rst_mode", 32'(bus.mode), 32'd0);
        check("rst_gain", 32'(bus.gain_shift), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        n_rst = 1'b0;

        do_tick(12'h001, 1'b0);
        check("single_se", 32'(bus.sample_enable), 32'h001);
        check("single_va", 32'(bus.voice_active), 32'h1);
        check("single_note0", 32'(bus.voice_notes[3:0]), 32'h0);
        check("single_gain", 32'(bus.gain_shift), 32'd0);
        check("single_update_hi", 32'(bus.update), 32'd1);
        @(posedge clk);
        #1;
        check("single_update_once", 32'(bus.update), 32'd0);

        do_tick(12'h01F, 1'b0);
        check("steal_se", 32'(bus.sample_enable), 32'h01E);
        check("steal_va", 32'(bus.voice_active), 32'hF);
        check("steal_gain", 32'(bus.gain_shift), 32'd2);
        do_tick(12'h01F, 1'b0);
        check("stolen_held_se", 32'(bus.sample_enable), 32'h01E);
        do_tick(12'h01E, 1'b0);
        check("release_stolen_se", 32'(bus.sample_enable), 32'h01E);
        do_tick(12'h01F, 1'b0);
        check("repress_se", 32'(bus.sample_enable), 32'h01D);

        // Second tick five cycles in must be dropped and flagged
        begin
            exp_t e;
            model_tick(bus.keys, e);
            sb_q.push_back(e);
            check("overrun_before", 32'(bus.overrun), 32'd0);
            @(posedge clk);
            #1;
            bus.sample_now = 1'b1;
            for (int c = 1; c <= 14; c++) begin
                @(posedge clk);
                #1;
                bus.sample_now = (c == 5);
                check("busy_window", 32'(bus.busy), (c <= 13) ? 32'd1 : 32'd0);
            end
            @(negedge clk);
            #1;
            check("overrun_set", 32'(bus.overrun), 32'd1);
            repeat (20) @(posedge clk);
            #1;
            check("single_commit", 32'(sb_q.size()), 32'd0);
            check("no_second_scan", 32'(bus.busy), 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.modekey = 1'b1;
            @(posedge clk);
            #1;
            bus.modekey = 1'b0;
            exp_mode = (exp_mode + 1) % 4;
            check("mode_step", 32'(bus.mode), 32'(exp_mode));
            check("mode_keeps_se", 32'(bus.sample_enable), 32'h01D);
        end

        do_reset();
        do_tick(12'h007, 1'b0);
        check("three_se", 32'(bus.sample_enable), 32'h007);
        pulse_tick(1'b0);
        repeat (6) @(posedge clk);
        #1;
        n_rst = 1'b1;
        #1;
        check("midscan_rst_se", 32'(bus.sample_enable), 32'd0);
        check("midscan_rst_va", 32'(bus.voice_active), 32'd0);
        check("midscan_rst_busy", 32'(bus.busy), 32'd0);
        check("midscan_rst_overrun", 32'(bus.overrun), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b0;
        model_reset();
        exp_mode = 0;
        sb_q.delete();
        do_tick(12'h007, 1'b0);
        check("rebuild_se", 32'(bus.sample_enable), 32'h007);
        check("rebuild_update", 32'(bus.update), 32'd1);

        for (int i = 0; i < 40; i++) begin
            logic [11:0] k;
            k = ($urandom_range(0, 2) == 0) ? 12'($urandom) : 12'($urandom & $urandom);
            do_tick(k, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
